// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, data word and the
// memory-arbiter state encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DACC  = 3'd1,
        IACC  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter for the single-ported RAM: data-first
// grants with fetch anti-starvation and a hung-access timeout.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      merr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    arb_state_t    state;
    logic          ifavor;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ifavor   <= 1'b0;
            cnt      <= '0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            merr     <= 1'b0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A pending fetch that lost to a data access wins next
                    if ((ifavor && iREN) || (iREN && !dREN && !dWEN)) begin
                        state    <= IACC;
                        ifavor   <= 1'b0;
                        cnt      <= '0;
                        ramREN   <= 1'b1;
                        ramWEN   <= 1'b0;
                        ramaddr  <= iaddr;
                        ramstore <= '0;
                    end else if (dREN || dWEN) begin
                        state    <= DACC;
                        cnt      <= '0;
                        ramREN   <= !dWEN;
                        ramWEN   <= dWEN;
                        ramaddr  <= daddr;
                        ramstore <= dWEN ? dstore : '0;
                    end
                end
                DACC, IACC: begin
                    if (ramstate == ERROR) begin
                        state    <= FAULT;
                        merr     <= 1'b1;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                    end else if (ramstate == ACCESS) begin
                        state    <= DONE;
                        ramREN   <= 1'b0;
                        ramWEN   <= 1'b0;
                        ramaddr  <= '0;
                        ramstore <= '0;
                        if (state == IACC) begin
                            ihit  <= 1'b1;
                            iload <= ramload;
                        end else begin
                            dhit <= 1'b1;
                            if (ramREN)
                                dload <= ramload;
                            if (iREN)
                                ifavor <= 1'b1;
                        end
                    end else begin
                        if (cnt != TMAX)
                            cnt <= cnt + 1'b1;
                        if (cnt == TLAST) begin
                            state    <= FAULT;
                            merr     <= 1'b1;
                            ramREN   <= 1'b0;
                            ramWEN   <= 1'b0;
                            ramaddr  <= '0;
                            ramstore <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                FAULT: begin
                    state    <= FAULT;
                    merr     <= 1'b1;
                    ramREN   <= 1'b0;
                    ramWEN   <= 1'b0;
                    ramaddr  <= '0;
                    ramstore <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      ihit, dhit, ramREN, ramWEN, merr;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .merr(merr)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ihit"}, 32'(ihit), 0);
        chk({tag, ".dhit"}, 32'(dhit), 0);
        chk({tag, ".iload"}, iload, 0);
        chk({tag, ".dload"}, dload, 0);
        chk({tag, ".ramREN"}, 32'(ramREN), 0);
        chk({tag, ".ramWEN"}, 32'(ramWEN), 0);
        chk({tag, ".ramaddr"}, ramaddr, 0);
        chk({tag, ".ramstore"}, ramstore, 0);
        chk({tag, ".merr"}, 32'(merr), 0);
    endtask

    initial begin
        // reset with random inputs
        RST = 1'b1;
        iREN = 1'($urandom); dREN = 1'($urandom); dWEN = 1'($urandom);
        iaddr = $urandom; daddr = $urandom; dstore = $urandom;
        ramload = $urandom; ramstate = ramstate_t'(2'($urandom));
        tick();
        tick();
        chk_zero("rst");
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        ramstate = FREE;
        RST = 1'b0;
        tick();
        chk("rst.merr_rel", 32'(merr), 0);
        chk("rst.idle_ren", 32'(ramREN), 0);

        // fetch with two BUSY cycles
        iREN = 1; iaddr = 32'h40; ramstate = BUSY;
        tick();
        chk("f.ramREN", 32'(ramREN), 1);
        chk("f.ramWEN", 32'(ramWEN), 0);
        chk("f.ramaddr", ramaddr, 32'h40);
        tick();
        chk("f.busy1_ihit", 32'(ihit), 0);
        tick();
        chk("f.busy2_ihit", 32'(ihit), 0);
        chk("f.busy2_addr", ramaddr, 32'h40);
        ramstate = ACCESS; ramload = 32'h8C220004;
        tick();
        chk("f.ihit", 32'(ihit), 1);
        chk("f.iload", iload, 32'h8C220004);
        chk("f.ren_clr", 32'(ramREN), 0);
        iREN = 0; ramstate = FREE;
        tick();
        chk("f.ihit_pulse", 32'(ihit), 0);
        chk("f.iload_hold", iload, 32'h8C220004);

        // simultaneous I and D: D first
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
        ramstate = ACCESS; ramload = 32'h11110100;
        tick();
        chk("s.d_grant_addr", ramaddr, 32'h100);
        chk("s.d_grant_ren", 32'(ramREN), 1);
        tick();
        chk("s.dhit", 32'(dhit), 1);
        chk("s.dload", dload, 32'h11110100);
        chk("s.no_ihit", 32'(ihit), 0);
        dREN = 0; ramload = 32'h22220044;
        tick();
        chk("s.done_dhit", 32'(dhit), 0);
        chk("s.done_ren", 32'(ramREN), 0);
        tick();
        chk("s.i_grant_addr", ramaddr, 32'h44);
        tick();
        chk("s.ihit", 32'(ihit), 1);
        chk("s.iload", iload, 32'h22220044);
        chk("s.dload_hold", dload, 32'h11110100);
        iREN = 0; ramstate = FREE;
        tick();

        // write (with dREN also high) while fetch waits
        iREN = 1; iaddr = 32'h48;
        dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        ramstate = ACCESS; ramload = 32'h99999999;
        tick();
        chk("w.ramWEN", 32'(ramWEN), 1);
        chk("w.ramREN", 32'(ramREN), 0);
        chk("w.ramstore", ramstore, 32'hDEADBEEF);
        chk("w.ramaddr", ramaddr, 32'h200);
        tick();
        chk("w.dhit", 32'(dhit), 1);
        chk("w.dload_keep", dload, 32'h11110100);
        dWEN = 0; dstore = 0; daddr = 32'h300; ramstate = BUSY;
        tick();
        tick();
        chk("a.i_first_addr", ramaddr, 32'h48);
        chk("a.i_first_ren", 32'(ramREN), 1);
        chk("a.i_first_store", ramstore, 0);
        ramstate = ACCESS; ramload = 32'h33330048;
        tick();
        chk("a.ihit", 32'(ihit), 1);
        chk("a.iload", iload, 32'h33330048);
        iREN = 0; ramload = 32'h44440300;
        tick();
        tick();
        chk("a.d_second_addr", ramaddr, 32'h300);
        tick();
        chk("a.dhit", 32'(dhit), 1);
        chk("a.dload", dload, 32'h44440300);
        dREN = 0; ramstate = FREE;
        tick();

        // timeout: RAM stuck BUSY
        dREN = 1; daddr = 32'h400; ramstate = BUSY;
        tick();
        chk("t.grant", 32'(ramREN), 1);
        for (int i = 0; i < 14; i++) tick();
        chk("t.14_merr", 32'(merr), 0);
        chk("t.14_ren", 32'(ramREN), 1);
        tick();
        chk("t.15_merr", 32'(merr), 1);
        chk("t.15_ren", 32'(ramREN), 0);
        chk("t.15_addr", ramaddr, 0);
        iREN = 1; iaddr = 32'h60; ramstate = ACCESS;
        for (int i = 0; i < 3; i++) tick();
        chk("t.stuck_ren", 32'(ramREN), 0);
        chk("t.stuck_ihit", 32'(ihit), 0);
        chk("t.stuck_dhit", 32'(dhit), 0);
        chk("t.stuck_merr", 32'(merr), 1);

        // leave fault by reset, then reset mid-fetch
        RST = 1; #2; RST = 0;
        dREN = 0; iREN = 1; iaddr = 32'h50; ramstate = BUSY;
        tick();
        chk("r.iacc_ren", 32'(ramREN), 1);
        chk("r.iacc_merr", 32'(merr), 0);
        RST = 1;
        #1;
        chk_zero("r.async");
        tick();
        RST = 0;
        ramstate = ACCESS; ramload = 32'h55550050;
        tick();
        chk("r.regrant", ramaddr, 32'h50);
        tick();
        chk("r.ihit", 32'(ihit), 1);
        chk("r.iload", iload, 32'h55550050);
        iREN = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
